// File: rtl/lvds_word_packer.sv
// lvds_word_packer: samples 4 LVDS lanes for SAMPLES clocks after a start edge and writes packed 32-bit words to the capture RAM
// Ports: LVDS_CLK/lvds_resetn (async, active-low) clock and reset; start capture request level;
//        lvds_in lane bits (lane L on bit L); mem_we/mem_addr/mem_wdata capture RAM write port;
//        busy high during capture; done_toggle inverts once per completed capture.
module lvds_word_packer #(
  parameter int SAMPLES = 4096,
  parameter int ADDR_W  = 9
) (
  input  logic              LVDS_CLK,
  input  logic              lvds_resetn,
  input  logic              start,
  input  logic [3:0]        lvds_in,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done_toggle
);
  typedef enum logic [1:0] {IDLE, CAPTURE, DONE} state_t;
  state_t state_cs, state_ns;
  logic              start_d;
  logic              rise;
  logic [ADDR_W+2:0] cnt;
  logic [27:0]       sh;
  assign rise = start & ~start_d;
  assign busy = state_cs == CAPTURE;
  always_ff @(posedge LVDS_CLK or negedge lvds_resetn)
    if (!lvds_resetn) state_cs <= IDLE;
    else state_cs <= state_ns;
  // SAMPLES == 8*2**ADDR_W, so the last sample is the all-ones counter value
  always_comb
    state_ns = state_cs == IDLE    ? (rise ? CAPTURE : IDLE) :
               state_cs == CAPTURE ? (&cnt ? DONE : CAPTURE) : IDLE;
  // sh holds the 7 older samples of the current word, oldest in the low nibble
  always_ff @(posedge LVDS_CLK or negedge lvds_resetn)
    if (!lvds_resetn) begin
      start_d     <= 1'b0;
      cnt         <= '0;
      sh          <= '0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      done_toggle <= 1'b0;
    end else begin
      start_d <= start;
      mem_we  <= 1'b0;
      if (state_cs == CAPTURE) begin
        cnt <= cnt + 1'b1;
        sh  <= {lvds_in, sh[27:4]};
        if (&cnt[2:0]) begin
          mem_we    <= 1'b1;
          mem_addr  <= cnt[ADDR_W+2:3];
          mem_wdata <= {lvds_in, sh};
        end
      end else if (state_cs == IDLE && rise) cnt <= '0;
      if (state_cs == DONE) done_toggle <= ~done_toggle;
    end
endmodule

// File: tb/tb_lvds_word_packer.sv
// tb_lvds_word_packer: directed self-checking bench for lvds_word_packer
module tb_lvds_word_packer;
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  lvds_in = 4'h0;
  logic        mem_we;
  logic [8:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        busy;
  logic        done_toggle;
  int          checks = 0;
  int          passed = 0;
  logic        tog = 1'b0;

  lvds_word_packer #(.SAMPLES(4096), .ADDR_W(9)) dut (
    .LVDS_CLK(clk), .lvds_resetn(resetn), .start(start), .lvds_in(lvds_in),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done_toggle(done_toggle)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] pat(input int mode, input int k);
    case (mode)
      0: return 4'hA;
      1: return k[3:0];
      2: return (k % 2 == 0) ? 4'h1 : 4'h0;
      default: return (k % 2 == 0) ? 4'h8 : 4'h0;
    endcase
  endfunction

  // One capture run; inputs change on the falling edge, outputs sampled there too.
  // Iteration c follows start-edge P0 plus c capture edges; word w is visible at c=8w+8.
  task automatic run(input string nm, input int mode, input bit hold, input int abort_at);
    int writes = 0, bad_a = 0, bad_d = 0, busy_n = 0, max_a = -1;
    logic [31:0] e;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    for (int c = 0; c <= 4100; c++) begin
      if (busy) busy_n++;
      if (mem_we) begin
        e = '0;
        for (int i = 0; i < 8; i++) e[4*i +: 4] = pat(mode, 8*writes + i);
        if (mem_addr !== 9'(writes)) bad_a++;
        if (mem_wdata !== e) bad_d++;
        max_a = int'(mem_addr);
        writes++;
      end
      if (c == abort_at) begin
        checks++;
        if (max_a != 124 || writes != 125) $display("FAIL %s pre_abort: max_addr %0d writes %0d, want 124 125", nm, max_a, writes);
        else passed++;
        #2 resetn = 1'b0;
        #1 checks++;
        if ({mem_we, mem_addr, mem_wdata, busy, done_toggle} !== '0)
          $display("FAIL %s async_reset: we %b addr %0d data %h busy %b tog %b, want all 0", nm, mem_we, mem_addr, mem_wdata, busy, done_toggle);
        else passed++;
        tog = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        repeat (2) @(negedge clk);
        return;
      end
      if (c == 4096) begin
        checks++;
        if (done_toggle !== tog) $display("FAIL %s toggle_early: got %b want %b", nm, done_toggle, tog);
        else passed++;
      end
      lvds_in = c < 4096 ? pat(mode, c) : 4'h0;
      if (!hold && c == 1) start = 1'b0;
      if (hold && (c == 1000 || c == 4095)) start = 1'b0;
      if (hold && (c == 1001 || c == 4096)) start = 1'b1;
      @(negedge clk);
    end
    tog = ~tog;
    checks++;
    if (done_toggle !== tog) $display("FAIL %s toggle: got %b want %b", nm, done_toggle, tog); else passed++;
    checks++;
    if (writes != 512) $display("FAIL %s writes: got %0d want 512", nm, writes); else passed++;
    checks++;
    if (bad_a != 0) $display("FAIL %s addr: %0d bad addresses, want 0", nm, bad_a); else passed++;
    checks++;
    if (bad_d != 0) $display("FAIL %s data: %0d bad words, want 0", nm, bad_d); else passed++;
    checks++;
    if (busy_n != 4096) $display("FAIL %s busy_cycles: got %0d want 4096", nm, busy_n); else passed++;
  endtask

  task automatic test_reset();
    #2 checks++;
    if ({mem_we, mem_addr, mem_wdata, busy, done_toggle} !== '0)
      $display("FAIL reset_state: we %b addr %0d data %h busy %b tog %b, want all 0", mem_we, mem_addr, mem_wdata, busy, done_toggle);
    else passed++;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || mem_we !== 1'b0) $display("FAIL idle_after_reset: busy %b we %b, want 0 0", busy, mem_we);
    else passed++;
  endtask

  task automatic test_retrigger();
    int stray = 0;
    run("retrigger", 1, 1'b1, -1);
    for (int c = 0; c < 900; c++) begin
      if (busy || mem_we) stray++;
      @(negedge clk);
    end
    checks++;
    if (stray != 0) $display("FAIL held_start: got %0d busy/write cycles want 0", stray); else passed++;
    start = 1'b0;
    @(negedge clk);
    run("second_run", 0, 1'b0, -1);
  endtask

  initial begin
    test_reset();
    run("constant", 0, 1'b0, -1);
    run("ramp", 1, 1'b0, -1);
    run("lane0", 2, 1'b0, -1);
    run("lane3", 3, 1'b0, -1);
    test_retrigger();
    run("abort", 1, 1'b0, 1001);
    run("after_abort", 1, 1'b0, -1);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
